// File: rtl/input_conditioner.sv
// N-channel input conditioner. Each channel has a synchroniser, a stable-count debounce
// filter, one-cycle rise/fall pulses and an optional hold-to-repeat pulse train.
module input_conditioner #(
  parameter int NUM_CH        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000000,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_RATE   = 10000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] repeat_pulse,
  output logic              any_active
);

  localparam int MAX_SR = (STABLE_CYCLES > REPEAT_RATE) ? STABLE_CYCLES : REPEAT_RATE;
  localparam int MAX_ALL = (MAX_SR > REPEAT_DELAY) ? MAX_SR : REPEAT_DELAY;
  localparam int CNT_W = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_M1  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_M1   = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    RP_IDLE  = 2'd0,
    RP_DELAY = 2'd1,
    RP_RATE  = 2'd2
  } rp_state_e;

  // Reset asserts asynchronously but releases only on a clock edge.
  logic [1:0] r_rst_pipe;
  logic       w_rst;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rst_pipe <= 2'b11;
    end else begin
      r_rst_pipe <= {r_rst_pipe[0], 1'b0};
    end
  end

  assign w_rst = r_rst_pipe[1];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_lvl;
    logic                   w_lvl_nxt;
    logic                   w_rise;
    logic                   w_fall;
    logic                   r_rise;
    logic                   r_fall;

    assign w_s = r_sync[SYNC_STAGES-1];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
      w_cnt_nxt = r_cnt;
      w_lvl_nxt = r_lvl;
      w_rise    = 1'b0;
      w_fall    = 1'b0;
      if (w_s == r_lvl) begin
        w_cnt_nxt = '0;
      end else if (r_cnt == STABLE_M1) begin
        w_lvl_nxt = w_s;
        w_cnt_nxt = '0;
        w_rise    = w_s;
        w_fall    = ~w_s;
      end else if (r_cnt != CNT_MAX) begin
        w_cnt_nxt = r_cnt + CNT_ONE;
      end
    end

    always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
        r_sync <= '0;
        r_cnt  <= '0;
        r_lvl  <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in[i]};
        r_cnt  <= w_cnt_nxt;
        r_lvl  <= w_lvl_nxt;
        r_rise <= w_rise;
        r_fall <= w_fall;
      end
    end

    assign level[i]      = r_lvl;
    assign rise_pulse[i] = r_rise;
    assign fall_pulse[i] = r_fall;

    if (REPEAT_EN != 0) begin : g_rep
      rp_state_e        r_state;
      rp_state_e        w_state_nxt;
      logic [CNT_W-1:0] r_rcnt;
      logic [CNT_W-1:0] w_rcnt_nxt;
      logic             r_rep;
      logic             w_rep_nxt;

      // A fall aborts the train before any repeat decision on the same edge.
      always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_rep_nxt   = 1'b0;
        if (w_fall) begin
          w_state_nxt = RP_IDLE;
          w_rcnt_nxt  = '0;
        end else begin
          case (r_state)
            RP_IDLE: begin
              if (w_rise) begin
                w_state_nxt = RP_DELAY;
                w_rcnt_nxt  = '0;
              end
            end
            RP_DELAY: begin
              if (r_rcnt == DELAY_M1) begin
                w_rep_nxt   = 1'b1;
                w_state_nxt = RP_RATE;
                w_rcnt_nxt  = '0;
              end else begin
                w_rcnt_nxt = r_rcnt + CNT_ONE;
              end
            end
            RP_RATE: begin
              if (r_rcnt == RATE_M1) begin
                w_rep_nxt  = 1'b1;
                w_rcnt_nxt = '0;
              end else begin
                w_rcnt_nxt = r_rcnt + CNT_ONE;
              end
            end
            default: begin
              w_state_nxt = RP_IDLE;
              w_rcnt_nxt  = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
          r_state <= RP_IDLE;
          r_rcnt  <= '0;
          r_rep   <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_rcnt  <= w_rcnt_nxt;
          r_rep   <= w_rep_nxt;
        end
      end

      assign repeat_pulse[i] = r_rep;
    end else begin : g_no_rep
      assign repeat_pulse[i] = 1'b0;
    end
  end

  logic r_any;

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |level;
    end
  end

  assign any_active = r_any;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: one DUT with repeat enabled, one without.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_in;
  logic [3:0] btn_nr;

  logic [3:0] level, rise_pulse, fall_pulse, repeat_pulse;
  logic       any_active;
  logic [3:0] level_nr, rise_nr, fall_nr, repeat_nr;
  logic       any_nr;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] acc;
  logic [31:0] h_rise, h_fall, h_rep;

  always #5 clk = ~clk;

  input_conditioner #(
    .NUM_CH(4), .SYNC_STAGES(2), .STABLE_CYCLES(4),
    .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) u_dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .level(level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .repeat_pulse(repeat_pulse), .any_active(any_active)
  );

  input_conditioner #(
    .NUM_CH(4), .SYNC_STAGES(2), .STABLE_CYCLES(4),
    .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) u_dut_nr (
    .clk(clk), .reset(reset), .btn_in(btn_nr),
    .level(level_nr), .rise_pulse(rise_nr), .fall_pulse(fall_nr),
    .repeat_pulse(repeat_nr), .any_active(any_nr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset state and clean release
    reset  = 1'b1;
    btn_in = 4'b0000;
    btn_nr = 4'b0000;
    repeat (3) step();
    check("reset_outputs", {15'd0, level, rise_pulse, fall_pulse, repeat_pulse, any_active}, 32'd0);
    check("reset_outputs_nr", {15'd0, level_nr, rise_nr, fall_nr, repeat_nr, any_nr}, 32'd0);
    reset = 1'b0;
    acc   = '0;
    for (int k = 0; k < 20; k++) begin
      step();
      acc = acc | {15'd0, level, rise_pulse, fall_pulse, repeat_pulse, any_active};
    end
    check("release_quiet", acc, 32'd0);

    // 2: press ch0, level and rise at t+5, any_active at t+6
    btn_in = 4'b0001;
    repeat (5) step();
    check("ch0_level_t4", {28'd0, level}, 32'h0);
    step();
    check("ch0_level_t5", {28'd0, level}, 32'h1);
    check("ch0_rise_t5", {28'd0, rise_pulse}, 32'h1);
    check("ch0_any_t5", {31'd0, any_active}, 32'h0);
    step();
    check("ch0_rise_t6", {28'd0, rise_pulse}, 32'h0);
    check("ch0_any_t6", {31'd0, any_active}, 32'h1);
    btn_in = 4'b0000;
    repeat (5) step();
    check("ch0_fall_t4", {28'd0, fall_pulse}, 32'h0);
    step();
    check("ch0_fall_t5", {28'd0, fall_pulse}, 32'h1);
    check("ch0_level_off", {28'd0, level}, 32'h0);
    step();
    check("ch0_fall_once", {28'd0, fall_pulse}, 32'h0);

    // 3: 3-cycle glitch on ch1, then a single low sample restarting the count
    acc    = '0;
    btn_in = 4'b0010;
    repeat (3) begin
      step();
      acc = acc | {29'd0, level[1], rise_pulse[1], fall_pulse[1]};
    end
    btn_in = 4'b0000;
    repeat (10) begin
      step();
      acc = acc | {29'd0, level[1], rise_pulse[1], fall_pulse[1]};
    end
    check("ch1_glitch", acc, 32'd0);
    btn_in = 4'b0010;
    repeat (3) step();
    btn_in = 4'b0000;
    step();
    btn_in = 4'b0010;
    repeat (5) step();
    check("ch1_restart_t4", {31'd0, level[1]}, 32'h0);
    step();
    check("ch1_restart_t5", {31'd0, rise_pulse[1]}, 32'h1);
    btn_in = 4'b0000;
    repeat (8) step();
    check("ch1_released", {28'd0, level}, 32'h0);

    // 4: hold ch2 for a repeat train, release so the fall lands on a repeat slot
    btn_in = 4'b0100;
    repeat (5) step();
    h_rise = '0;
    h_fall = '0;
    h_rep  = '0;
    for (int k = 0; k <= 30; k++) begin
      step();
      h_rise[k] = rise_pulse[2];
      h_fall[k] = fall_pulse[2];
      h_rep[k]  = repeat_pulse[2];
      if (k == 16) btn_in = 4'b0000;
    end
    check("ch2_rise_hist", h_rise, 32'h0000_0001);
    check("ch2_fall_hist", h_fall, 32'h0040_0000);
    check("ch2_rep_hist", h_rep, 32'h0009_2400);

    // 5: all channels at once, then reset mid-hold
    btn_in = 4'b1111;
    repeat (6) step();
    check("all_rise", {28'd0, rise_pulse}, 32'hF);
    check("all_level", {28'd0, level}, 32'hF);
    repeat (3) step();
    reset  = 1'b1;
    btn_in = 4'b0000;
    #2;
    check("async_clear", {27'd0, level, any_active}, 32'd0);
    acc = '0;
    repeat (3) begin
      step();
      acc = acc | {20'd0, level, rise_pulse, fall_pulse, repeat_pulse};
    end
    reset = 1'b0;
    repeat (20) begin
      step();
      acc = acc | {20'd0, level, rise_pulse, fall_pulse, repeat_pulse};
    end
    check("reset_no_pulses", acc, 32'd0);

    // 6: repeat disabled build, long hold on ch3
    btn_nr = 4'b1000;
    repeat (5) step();
    check("nr_level_t4", {28'd0, level_nr}, 32'h0);
    step();
    check("nr_rise_t5", {28'd0, rise_nr}, 32'h8);
    acc = '0;
    repeat (100) begin
      step();
      acc = acc | {28'd0, repeat_nr};
    end
    check("nr_no_repeat", acc, 32'd0);
    check("nr_level_held", {28'd0, level_nr}, 32'h8);
    btn_nr = 4'b0000;
    repeat (5) step();
    check("nr_fall_t4", {28'd0, fall_nr}, 32'h0);
    step();
    check("nr_fall_t5", {28'd0, fall_nr}, 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
